// File: rtl/id_stage.sv
// Instruction-decode stage: register file, decoder, load-use stall and ID/EX register.
module id_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned REGSIZE = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_instr,
    input  logic [WIDTH-1:0]   in_pc,
    input  logic               flush,
    input  logic               wb_en,
    input  logic [4:0]         wb_addr,
    input  logic [REGSIZE-1:0] wb_data,
    output logic               ex_valid,
    output logic [5:0]         ex_opcode,
    output logic [5:0]         ex_funct,
    output logic [REGSIZE-1:0] ex_first,
    output logic [REGSIZE-1:0] ex_second,
    output logic [REGSIZE-1:0] ex_store_data,
    output logic [4:0]         ex_dest,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic [WIDTH-1:0]   ex_link,
    output logic [WIDTH-1:0]   ex_branch_target,
    output logic [WIDTH-1:0]   ex_jump_target,
    output logic               illegal
);

    localparam int unsigned NREGS  = 32;
    localparam logic [5:0]  OP_R   = 6'd0;
    localparam logic [5:0]  OP_J   = 6'd2;
    localparam logic [5:0]  OP_JAL = 6'd3;
    localparam logic [5:0]  OP_LW  = 6'd4;
    localparam logic [5:0]  OP_SW  = 6'd5;
    localparam logic [5:0]  OP_BEQ = 6'd6;
    localparam logic [5:0]  FUNCT_MAX = 6'd4;
    localparam logic [4:0]  LINK_REG  = 5'd31;

    typedef struct packed {
        logic               valid;
        logic [5:0]         opcode;
        logic [5:0]         funct;
        logic [REGSIZE-1:0] first;
        logic [REGSIZE-1:0] second;
        logic [REGSIZE-1:0] store_data;
        logic [4:0]         dest;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               jump;
        logic [WIDTH-1:0]   link;
        logic [WIDTH-1:0]   branch_target;
        logic [WIDTH-1:0]   jump_target;
    } idex_t;

    logic [REGSIZE-1:0] rf [NREGS];
    idex_t              idex_q, idex_d;
    logic               illegal_q, illegal_d;

    logic [5:0]         op, fn;
    logic [4:0]         rs, rt, rd;
    logic [REGSIZE-1:0] imm_ext, rs_val, rt_val;
    logic [WIDTH-1:0]   pc4, br_off, jtarget;
    logic               is_r, legal, reads_rs, reads_rt, hazard;

    assign op = in_instr[31:26];
    assign rs = in_instr[25:21];
    assign rt = in_instr[20:16];
    assign rd = in_instr[15:11];
    assign fn = in_instr[5:0];

    assign imm_ext = REGSIZE'({{(REGSIZE-16){in_instr[15]}}, in_instr[15:0]});
    assign pc4     = in_pc + WIDTH'(4);
    assign br_off  = WIDTH'({{(WIDTH-16){in_instr[15]}}, in_instr[15:0]}) << 2;
    assign jtarget = WIDTH'({pc4[WIDTH-1:WIDTH-4], in_instr[25:0], 2'b00});

    // Register read with write-back bypass; r0 is never bypassed
    assign rs_val = (wb_en && wb_addr == rs && rs != 5'd0) ? wb_data : rf[rs];
    assign rt_val = (wb_en && wb_addr == rt && rt != 5'd0) ? wb_data : rf[rt];

    // Classify the incoming instruction and detect a load-use dependency
    always_comb begin
        is_r     = (op == OP_R) && (fn <= FUNCT_MAX);
        legal    = is_r || op == OP_LW || op == OP_SW || op == OP_BEQ
                   || op == OP_J || op == OP_JAL;
        reads_rs = is_r || op == OP_LW || op == OP_SW || op == OP_BEQ;
        reads_rt = is_r || op == OP_SW || op == OP_BEQ;
        hazard   = idex_q.valid && idex_q.mem_read && (idex_q.dest != 5'd0)
                   && ((reads_rs && rs == idex_q.dest) || (reads_rt && rt == idex_q.dest));
    end

    // Ready whenever no stall is pending; flush consumes and drops the instruction
    assign in_ready = !rst_n || !hazard || flush;

    // Next ID/EX contents: bubble unless a legal instruction is accepted
    always_comb begin
        idex_d    = '0;
        illegal_d = 1'b0;
        if (in_valid && !flush && !hazard) begin
            if (!legal) begin
                illegal_d = 1'b1;
            end else begin
                idex_d.valid         = 1'b1;
                idex_d.opcode        = op;
                idex_d.funct         = fn;
                idex_d.link          = pc4;
                idex_d.branch_target = pc4 + br_off;
                idex_d.jump_target   = jtarget;
                case (op)
                    OP_R: begin
                        idex_d.first     = rs_val;
                        idex_d.second    = rt_val;
                        idex_d.dest      = rd;
                        idex_d.reg_write = (rd != 5'd0);
                    end
                    OP_LW: begin
                        idex_d.first     = rs_val;
                        idex_d.second    = imm_ext;
                        idex_d.dest      = rt;
                        idex_d.mem_read  = 1'b1;
                        idex_d.reg_write = (rt != 5'd0);
                    end
                    OP_SW: begin
                        idex_d.first      = rs_val;
                        idex_d.second     = imm_ext;
                        idex_d.store_data = rt_val;
                        idex_d.mem_write  = 1'b1;
                    end
                    OP_BEQ: begin
                        idex_d.first  = rs_val;
                        idex_d.second = rt_val;
                        idex_d.branch = 1'b1;
                    end
                    OP_J: begin
                        idex_d.jump = 1'b1;
                    end
                    OP_JAL: begin
                        idex_d.jump      = 1'b1;
                        idex_d.dest      = LINK_REG;
                        idex_d.reg_write = 1'b1;
                    end
                    default: begin
                        idex_d.valid = 1'b0;
                    end
                endcase
            end
        end
    end

    // ID/EX pipeline register and illegal-instruction pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            idex_q    <= idex_d;
            illegal_q <= illegal_d;
        end
    end

    // Register file write-back; r0 stays zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en && wb_addr != 5'd0) begin
            rf[wb_addr] <= wb_data;
        end
    end

    assign ex_valid         = idex_q.valid;
    assign ex_opcode        = idex_q.opcode;
    assign ex_funct         = idex_q.funct;
    assign ex_first         = idex_q.first;
    assign ex_second        = idex_q.second;
    assign ex_store_data    = idex_q.store_data;
    assign ex_dest          = idex_q.dest;
    assign ex_reg_write     = idex_q.reg_write;
    assign ex_mem_read      = idex_q.mem_read;
    assign ex_mem_write     = idex_q.mem_write;
    assign ex_branch        = idex_q.branch;
    assign ex_jump          = idex_q.jump;
    assign ex_link          = idex_q.link;
    assign ex_branch_target = idex_q.branch_target;
    assign ex_jump_target   = idex_q.jump_target;
    assign illegal          = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for the decode stage.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, wb_en;
    logic [31:0] in_instr, in_pc, wb_data;
    logic [4:0]  wb_addr;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, illegal;
    logic [5:0]  ex_opcode, ex_funct;
    logic [31:0] ex_first, ex_second, ex_store_data, ex_link, ex_branch_target, ex_jump_target;
    logic [4:0]  ex_dest;

    int compared = 0;
    int mism     = 0;

    id_stage #(.WIDTH(32), .REGSIZE(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_first(ex_first), .ex_second(ex_second), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_link(ex_link), .ex_branch_target(ex_branch_target),
        .ex_jump_target(ex_jump_target), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        compared++; if (in_ready !== 1'b1) begin mism++; $display("FAIL reset_ready_during got %b want 1", in_ready); end
        step(); step();
        compared++; if (ex_valid !== 1'b0) begin mism++; $display("FAIL reset_valid got %b want 0", ex_valid); end
        compared++; if (ex_first !== 32'd0) begin mism++; $display("FAIL reset_first got %h want 0", ex_first); end
        compared++; if (illegal !== 1'b0) begin mism++; $display("FAIL reset_illegal got %b want 0", illegal); end
        rst_n = 1'b1;
        step();
        compared++; if (in_ready !== 1'b1) begin mism++; $display("FAIL reset_ready_after got %b want 1", in_ready); end
    endtask

    task automatic test_rtype();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'd7;
        step();
        wb_addr = 5'd6; wb_data = 32'd3;
        step();
        wb_en = 1'b0;
        in_valid = 1'b1; in_instr = rtype(5'd5, 5'd6, 5'd1, 6'd0); in_pc = 32'h40;
        step();
        compared++; if (ex_first !== 32'd7) begin mism++; $display("FAIL add_first got %h want 7", ex_first); end
        compared++; if (ex_second !== 32'd3) begin mism++; $display("FAIL add_second got %h want 3", ex_second); end
        compared++; if (ex_dest !== 5'd1) begin mism++; $display("FAIL add_dest got %0d want 1", ex_dest); end
        compared++; if (ex_reg_write !== 1'b1) begin mism++; $display("FAIL add_regwrite got %b want 1", ex_reg_write); end
        compared++; if (ex_valid !== 1'b1) begin mism++; $display("FAIL add_valid got %b want 1", ex_valid); end
        compared++; if (ex_link !== 32'h44) begin mism++; $display("FAIL add_link got %h want 44", ex_link); end
    endtask

    task automatic test_load_use();
        in_instr = itype(6'd4, 5'd5, 5'd2, 16'hFFFC);
        step();
        compared++; if (ex_second !== 32'hFFFFFFFC) begin mism++; $display("FAIL lw_second got %h want fffffffc", ex_second); end
        compared++; if (ex_mem_read !== 1'b1) begin mism++; $display("FAIL lw_memread got %b want 1", ex_mem_read); end
        compared++; if (ex_dest !== 5'd2) begin mism++; $display("FAIL lw_dest got %0d want 2", ex_dest); end
        in_instr = rtype(5'd2, 5'd6, 5'd3, 6'd1);
        #1;
        compared++; if (in_ready !== 1'b0) begin mism++; $display("FAIL hazard_ready got %b want 0", in_ready); end
        step();
        compared++; if (ex_valid !== 1'b0) begin mism++; $display("FAIL hazard_bubble got %b want 0", ex_valid); end
        compared++; if (ex_mem_read !== 1'b0) begin mism++; $display("FAIL hazard_bubble_ctl got %b want 0", ex_mem_read); end
        compared++; if (in_ready !== 1'b1) begin mism++; $display("FAIL hazard_clear got %b want 1", in_ready); end
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h10;
        step();
        wb_en = 1'b0;
        compared++; if (ex_valid !== 1'b1) begin mism++; $display("FAIL sub_valid got %b want 1", ex_valid); end
        compared++; if (ex_first !== 32'h10) begin mism++; $display("FAIL sub_first_bypass got %h want 10", ex_first); end
        compared++; if (ex_funct !== 6'd1) begin mism++; $display("FAIL sub_funct got %0d want 1", ex_funct); end
    endtask

    task automatic test_bypass_sw();
        in_instr = itype(6'd5, 5'd5, 5'd4, 16'h0008);
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h55;
        step();
        compared++; if (ex_store_data !== 32'h55) begin mism++; $display("FAIL sw_store got %h want 55", ex_store_data); end
        compared++; if (ex_second !== 32'd8) begin mism++; $display("FAIL sw_second got %h want 8", ex_second); end
        compared++; if (ex_mem_write !== 1'b1) begin mism++; $display("FAIL sw_memwrite got %b want 1", ex_mem_write); end
        compared++; if (ex_reg_write !== 1'b0) begin mism++; $display("FAIL sw_regwrite got %b want 0", ex_reg_write); end
        in_instr = rtype(5'd0, 5'd0, 5'd7, 6'd0);
        wb_addr = 5'd0; wb_data = 32'h99;
        step();
        compared++; if (ex_first !== 32'd0) begin mism++; $display("FAIL r0_bypass got %h want 0", ex_first); end
        wb_en = 1'b0;
        step();
        compared++; if (ex_second !== 32'd0) begin mism++; $display("FAIL r0_stored got %h want 0", ex_second); end
    endtask

    task automatic test_jal();
        in_instr = {6'd3, 26'h100}; in_pc = 32'h00400010;
        step();
        compared++; if (ex_link !== 32'h00400014) begin mism++; $display("FAIL jal_link got %h want 00400014", ex_link); end
        compared++; if (ex_jump_target !== 32'h00000400) begin mism++; $display("FAIL jal_target got %h want 00000400", ex_jump_target); end
        compared++; if (ex_dest !== 5'd31) begin mism++; $display("FAIL jal_dest got %0d want 31", ex_dest); end
        compared++; if (ex_jump !== 1'b1) begin mism++; $display("FAIL jal_jump got %b want 1", ex_jump); end
        compared++; if (ex_first !== 32'd0) begin mism++; $display("FAIL jal_first got %h want 0", ex_first); end
    endtask

    task automatic test_beq_illegal();
        in_instr = itype(6'd6, 5'd5, 5'd6, 16'hFFFF); in_pc = 32'h100;
        step();
        compared++; if (ex_branch_target !== 32'h100) begin mism++; $display("FAIL beq_target got %h want 100", ex_branch_target); end
        compared++; if (ex_branch !== 1'b1) begin mism++; $display("FAIL beq_branch got %b want 1", ex_branch); end
        compared++; if (ex_second !== 32'd3) begin mism++; $display("FAIL beq_second got %h want 3", ex_second); end
        in_instr = 32'hFC000000;
        step();
        compared++; if (illegal !== 1'b1) begin mism++; $display("FAIL ill_op_pulse got %b want 1", illegal); end
        compared++; if (ex_valid !== 1'b0) begin mism++; $display("FAIL ill_op_valid got %b want 0", ex_valid); end
        in_instr = rtype(5'd1, 5'd2, 5'd3, 6'd5);
        step();
        compared++; if (illegal !== 1'b1) begin mism++; $display("FAIL ill_funct_pulse got %b want 1", illegal); end
        in_valid = 1'b0;
        step();
        compared++; if (illegal !== 1'b0) begin mism++; $display("FAIL ill_pulse_end got %b want 0", illegal); end
    endtask

    task automatic test_flush_stall();
        in_valid = 1'b1; in_instr = itype(6'd4, 5'd5, 5'd2, 16'h0000);
        step();
        in_instr = rtype(5'd2, 5'd6, 5'd8, 6'd0);
        #1;
        compared++; if (in_ready !== 1'b0) begin mism++; $display("FAIL flush_pre_ready got %b want 0", in_ready); end
        flush = 1'b1;
        #1;
        compared++; if (in_ready !== 1'b1) begin mism++; $display("FAIL flush_ready got %b want 1", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        compared++; if (ex_valid !== 1'b0) begin mism++; $display("FAIL flush_valid got %b want 0", ex_valid); end
        compared++; if (ex_reg_write !== 1'b0) begin mism++; $display("FAIL flush_regwrite got %b want 0", ex_reg_write); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_instr = itype(6'd4, 5'd5, 5'd0, 16'h0004);
        step();
        compared++; if (ex_reg_write !== 1'b0) begin mism++; $display("FAIL lw_r0_regwrite got %b want 0", ex_reg_write); end
        in_instr = rtype(5'd0, 5'd6, 5'd9, 6'd2);
        #1;
        compared++; if (in_ready !== 1'b1) begin mism++; $display("FAIL lw_r0_noharzard got %b want 1", in_ready); end
        step();
        compared++; if (ex_second !== 32'd3) begin mism++; $display("FAIL b2b_a_second got %h want 3", ex_second); end
        in_instr = rtype(5'd6, 5'd5, 5'd10, 6'd3);
        step();
        compared++; if (ex_first !== 32'd3) begin mism++; $display("FAIL b2b_b_first got %h want 3", ex_first); end
        compared++; if (ex_dest !== 5'd10) begin mism++; $display("FAIL b2b_b_dest got %0d want 10", ex_dest); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_instr = itype(6'd4, 5'd5, 5'd2, 16'h0000);
        step();
        in_instr = rtype(5'd2, 5'd6, 5'd1, 6'd0);
        #1;
        compared++; if (in_ready !== 1'b0) begin mism++; $display("FAIL rstmid_stall got %b want 0", in_ready); end
        rst_n = 1'b0;
        #1;
        compared++; if (in_ready !== 1'b1) begin mism++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
        step();
        compared++; if (ex_valid !== 1'b0) begin mism++; $display("FAIL rstmid_valid got %b want 0", ex_valid); end
        compared++; if (ex_dest !== 5'd0) begin mism++; $display("FAIL rstmid_dest got %0d want 0", ex_dest); end
        compared++; if (ex_link !== 32'd0) begin mism++; $display("FAIL rstmid_link got %h want 0", ex_link); end
        compared++; if (ex_mem_read !== 1'b0) begin mism++; $display("FAIL rstmid_memread got %b want 0", ex_mem_read); end
        rst_n = 1'b1;
        step();
        compared++; if (ex_valid !== 1'b1) begin mism++; $display("FAIL rstmid_issue got %b want 1", ex_valid); end
        compared++; if (ex_second !== 32'd0) begin mism++; $display("FAIL rstmid_reg_cleared got %h want 0", ex_second); end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_use();
        test_bypass_sw();
        test_jal();
        test_beq_illegal();
        test_flush_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
